ifft_cp_inserter: RTL and testbench

//  Downstream consumer of the ifft block. Steps ifft's sel input through 0..N-1 and

---
 rtl/ifft_cp_inserter_pkg.sv | 20 ++
 rtl/ifft_cp_inserter_if.sv | 14 +
 rtl/ifft_sample_buf.sv | 26 ++
 rtl/ifft_cp_inserter.sv | 151 +++++++++++++++
 tb/tb_ifft_cp_inserter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/ifft_cp_inserter_pkg.sv
// Shared defaults, FSM encoding and sizing helper for the ifft cyclic-prefix inserter.
package ifft_cp_inserter_pkg;

   localparam int unsigned DEF_N       = 8;
   localparam int unsigned DEF_W       = 12;
   localparam int unsigned DEF_CP_LEN  = 2;
   localparam int unsigned DEF_SEL_LAT = 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      STREAM  = 2'd2
   } state_t;

   // Bits needed to count 0..x-1, never less than one.
   function automatic int unsigned cw(input int unsigned x);
      return (x > 1) ? $clog2(x) : 1;
   endfunction

endpackage

// File: rtl/ifft_cp_inserter_if.sv
// Valid/ready sample stream carrying one complex beat plus symbol framing flags.
interface ifft_cp_inserter_if #(
   parameter int unsigned W = 12
);
   logic         valid;
   logic         ready;
   logic [W-1:0] re;
   logic [W-1:0] im;
   logic         first;
   logic         last;

   modport master (output valid, re, im, first, last, input ready);
   modport slave  (input valid, re, im, first, last, output ready);
endinterface

// File: rtl/ifft_sample_buf.sv
// N-entry complex sample register file: one synchronous write port, one async read port.
module ifft_sample_buf #(
   parameter int unsigned N  = 8,
   parameter int unsigned W  = 12,
   parameter int unsigned AW = 3
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wre,
   input  logic [W-1:0]  wim,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rre,
   output logic [W-1:0]  rim
);

   logic [2*W-1:0] mem [N];

   // Contents are only ever read after a full capture, so no reset is needed.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= {wre, wim};
   end

   assign {rre, rim} = mem[raddr];

endmodule

// File: rtl/ifft_cp_inserter.sv
// Captures one ifft output symbol by stepping sel, then streams it with a cyclic prefix.
module ifft_cp_inserter
   import ifft_cp_inserter_pkg::*;
#(
   parameter int unsigned N       = DEF_N,
   parameter int unsigned W       = DEF_W,
   parameter int unsigned CP_LEN  = DEF_CP_LEN,
   parameter int unsigned SEL_LAT = DEF_SEL_LAT,
   localparam int unsigned SW     = cw(N)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   output logic [SW-1:0]       sel,
   input  logic [W-1:0]        yr,
   input  logic [W-1:0]        yi,
   output logic                busy,
   ifft_cp_inserter_if.master  out
);

   localparam int unsigned NB = N + CP_LEN;
   localparam int unsigned HW = cw(SEL_LAT + 1);
   localparam int unsigned BW = cw(NB);

   state_t         state, state_d;
   logic [SW-1:0]  sel_d;
   logic [HW-1:0]  hold, hold_d;
   logic [BW-1:0]  beat, beat_d;
   logic           busy_d, valid_d, first_d, last_d, load, we;
   logic [W-1:0]   re_d, im_d, rre, rim;
   logic [SW-1:0]  raddr;

   // Beat index to buffer index: prefix beats replay the symbol tail.
   function automatic logic [SW-1:0] beat_sample(input logic [BW-1:0] b);
      int bi;
      bi = int'(b);
      if (bi < int'(CP_LEN)) return SW'(bi + int'(N) - int'(CP_LEN));
      return SW'(bi - int'(CP_LEN));
   endfunction

   ifft_sample_buf #(.N(N), .W(W), .AW(SW)) u_buf (
      .clk   (clk),
      .we    (we),
      .waddr (sel),
      .wre   (yr),
      .wim   (yi),
      .raddr (raddr),
      .rre   (rre),
      .rim   (rim)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         sel       <= '0;
         hold      <= '0;
         beat      <= '0;
         busy      <= 1'b0;
         out.valid <= 1'b0;
         out.re    <= '0;
         out.im    <= '0;
         out.first <= 1'b0;
         out.last  <= 1'b0;
      end else begin
         state     <= state_d;
         sel       <= sel_d;
         hold      <= hold_d;
         beat      <= beat_d;
         busy      <= busy_d;
         out.valid <= valid_d;
         out.re    <= re_d;
         out.im    <= im_d;
         out.first <= first_d;
         out.last  <= last_d;
      end
   end

   always_comb begin
      state_d = state;
      sel_d   = sel;
      hold_d  = hold;
      beat_d  = beat;
      busy_d  = busy;
      valid_d = out.valid;
      re_d    = out.re;
      im_d    = out.im;
      first_d = out.first;
      last_d  = out.last;
      load    = 1'b0;
      we      = 1'b0;

      unique case (state)
         IDLE: begin
            if (start) begin
               state_d = CAPTURE;
               busy_d  = 1'b1;
               sel_d   = '0;
               hold_d  = '0;
            end
         end
         CAPTURE: begin
            // Each sel is held until the ifft output has settled, then captured.
            if (hold == HW'(SEL_LAT)) begin
               we     = 1'b1;
               hold_d = '0;
               if (sel == SW'(N - 1)) begin
                  state_d = STREAM;
                  sel_d   = '0;
                  beat_d  = '0;
                  valid_d = 1'b1;
                  load    = 1'b1;
               end else begin
                  sel_d = sel + SW'(1);
               end
            end else begin
               hold_d = hold + HW'(1);
            end
         end
         STREAM: begin
            if (out.valid && out.ready) begin
               if (beat == BW'(NB - 1)) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  valid_d = 1'b0;
                  first_d = 1'b0;
                  last_d  = 1'b0;
               end else begin
                  beat_d = beat + BW'(1);
                  load   = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Bypass covers the prefix sample being written on the final capture edge.
      raddr = beat_sample(beat_d);
      if (load) begin
         if (we && (raddr == sel)) begin
            re_d = yr;
            im_d = yi;
         end else begin
            re_d = rre;
            im_d = rim;
         end
         first_d = (beat_d == '0);
         last_d  = (beat_d == BW'(NB - 1));
      end
   end

endmodule

// File: tb/tb_ifft_cp_inserter.sv
// Scoreboard bench: three inserter configurations fed by ifft latency models share start/rst/ready.
module tb_ifft_cp_inserter;

   localparam int N = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       rdy = 1'b1;
   logic       bp = 1'b0;
   int         ph = 0;
   int         n_chk = 0;
   int         n_pass = 0;
   logic [2:0] busy_v, pend_v;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, got, exp, $time);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Ready pattern 1,0,0 repeating while backpressure is enabled.
   always @(posedge clk) begin
      #1;
      rdy = bp ? (ph == 0) : 1'b1;
      ph  = (ph + 1) % 3;
   end

   for (genvar k = 0; k < 3; k++) begin : g
      localparam int CP  = (k == 0) ? 2 : (k == 1) ? 0 : 8;
      localparam int LAT = (k == 0) ? 1 : (k == 1) ? 0 : 2;
      localparam int NB  = N + CP;

      logic [2:0]  sel, sd;
      logic [2:0]  pipe [2];
      logic [11:0] yr, yi;
      logic        busy;
      logic [25:0] q [$];
      logic [25:0] held;
      bit          idle = 1'b1, stalled = 1'b0, post = 1'b0, pend = 1'b0;
      int          cap = 0, scnt = 0, nsym = 0;

      ifft_cp_inserter_if #(.W(12)) bus ();
      assign bus.ready = rdy;

      ifft_cp_inserter #(.N(N), .W(12), .CP_LEN(CP), .SEL_LAT(LAT)) dut (
         .clk   (clk),
         .rst   (rst),
         .start (start),
         .sel   (sel),
         .yr    (yr),
         .yi    (yi),
         .busy  (busy),
         .out   (bus)
      );

      // ifft model: yr = 100+sel, yi = -(sel+1), LAT cycles behind sel.
      always @(posedge clk) begin
         pipe[0] <= sel;
         pipe[1] <= pipe[0];
      end
      always_comb begin
         case (LAT)
            0:       sd = sel;
            1:       sd = pipe[0];
            default: sd = pipe[1];
         endcase
      end
      assign yr = 12'(100 + int'(sd));
      assign yi = 12'(-(int'(sd) + 1));

      assign busy_v[k] = busy;
      assign pend_v[k] = pend;

      always @(negedge clk) begin
         logic [25:0] cur, e;
         int s;
         if (rst) begin
            q.delete();
            idle = 1'b1; stalled = 1'b0; post = 1'b0; cap = 0; scnt = 0;
         end else begin
            cur = {bus.re, bus.im, bus.first, bus.last};
            if (post) chk("idle_after_last", {30'd0, busy, bus.valid}, 32'd0);
            post = 1'b0;
            if (stalled) chk("stall_hold", {5'd0, bus.valid, cur}, {5'd0, 1'b1, held});
            if (busy && !bus.valid) cap++;
            else if (bus.valid && cap != 0) begin
               chk("capture_len", cap, N * (LAT + 1));
               cap = 0;
            end
            if (start && idle) begin
               for (int b = 0; b < NB; b++) begin
                  s = (b < CP) ? N - CP + b : b - CP;
                  q.push_back({12'(100 + s), 12'(-(s + 1)), b == 0, b == NB - 1});
               end
               idle = 1'b0;
            end
            if (bus.valid && bus.ready) begin
               if (q.size() == 0) chk("unexpected_beat", 32'd1, 32'd0);
               else begin
                  e = q.pop_front();
                  chk("beat_re", 32'(bus.re), 32'(e[25:14]));
                  chk("beat_im", 32'(bus.im), 32'(e[13:2]));
                  chk("beat_first", 32'(bus.first), 32'(e[1]));
                  chk("beat_last", 32'(bus.last), 32'(e[0]));
                  scnt++;
                  if (e[0]) begin
                     chk("beats_per_symbol", scnt, NB);
                     scnt = 0; nsym++; idle = 1'b1; post = 1'b1;
                  end
               end
            end
            stalled = bus.valid && !bus.ready;
            held    = cur;
         end
         pend = (q.size() != 0);
      end
   end

   task automatic wait_done(input string tag);
      for (int i = 0; i < 600; i++) begin
         if (busy_v == 3'b0 && pend_v == 3'b0) return;
         tick(1);
      end
      chk({tag, "_timeout"}, 32'd1, 32'd0);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   initial begin
      int s0;
      bit seen;
      tick(2);
      chk("rst_sel", 32'(g[0].sel), 32'd0);
      chk("rst_busy", 32'(g[0].busy), 32'd0);
      chk("rst_valid", 32'(g[0].bus.valid), 32'd0);
      chk("rst_data", {8'd0, g[0].bus.re, g[0].bus.im}, 32'd0);
      chk("rst_flags", {30'd0, g[0].bus.first, g[0].bus.last}, 32'd0);
      rst = 1'b0;
      tick(2);

      // Basic symbol with ready held high.
      pulse_start();
      wait_done("basic");

      // Backpressure.
      bp = 1'b1;
      tick(1);
      pulse_start();
      wait_done("backpressure");
      bp = 1'b0;
      tick(2);

      // start held high through capture and part of stream, then restart on first IDLE cycle.
      s0 = g[0].nsym;
      start = 1'b1;
      tick(20);
      start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (busy_v[0] == 1'b0) begin seen = 1'b1; break; end
         tick(1);
      end
      chk("first_idle_seen", 32'(seen), 32'd1);
      chk("held_start_one_symbol", g[0].nsym - s0, 32'd1);
      pulse_start();
      wait_done("restart");
      chk("restart_two_symbols", g[0].nsym - s0, 32'd2);
      tick(2);

      // Reset after the third beat is accepted.
      pulse_start();
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (g[0].scnt == 3) begin seen = 1'b1; break; end
         tick(1);
      end
      chk("third_beat_seen", 32'(seen), 32'd1);
      rst = 1'b1;
      #1;
      chk("midrst_valid", 32'(g[0].bus.valid), 32'd0);
      chk("midrst_sel", 32'(g[0].sel), 32'd0);
      chk("midrst_busy", 32'(g[0].busy), 32'd0);
      tick(1);
      rst = 1'b0;
      tick(1);
      s0 = g[0].nsym;
      pulse_start();
      wait_done("post_reset");
      chk("post_reset_symbol", g[0].nsym - s0, 32'd1);
      tick(2);

      // rst and start asserted together: nothing starts.
      rst = 1'b1;
      start = 1'b1;
      tick(1);
      rst = 1'b0;
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("rst_start_sel", 32'(g[0].sel), 32'd0);
         chk("rst_start_busy", {29'd0, busy_v}, 32'd0);
         tick(1);
      end

      chk("drained", {29'd0, pend_v}, 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
